// File: rtl/seven_seg_scan_n_if.sv
// ---------------------------------------------------------------------------
// seven_seg_scan_n_if
// Bundle of the display driver's data and pin signals.
//   master : the calculator side plus an observer of the panel pins
//            (drives load/value/dp_in/digit_en/blank_lz/blink_mask,
//             receives seg_n/dp_n/an_n/frame_done)
//   slave  : the scanner itself (the mirror of master)
// ---------------------------------------------------------------------------
interface seven_seg_scan_n_if #(
    parameter int DIGITS = 4
);
    logic                  load;
    logic [4*DIGITS-1:0]   value;
    logic [DIGITS-1:0]     dp_in;
    logic [DIGITS-1:0]     digit_en;
    logic                  blank_lz;
    logic [DIGITS-1:0]     blink_mask;
    logic [6:0]            seg_n;
    logic                  dp_n;
    logic [DIGITS-1:0]     an_n;
    logic                  frame_done;

    modport master (
        output load, value, dp_in, digit_en, blank_lz, blink_mask,
        input  seg_n, dp_n, an_n, frame_done
    );

    modport slave (
        input  load, value, dp_in, digit_en, blank_lz, blink_mask,
        output seg_n, dp_n, an_n, frame_done
    );
endinterface

// File: rtl/seven_seg_scan_n.sv
// ---------------------------------------------------------------------------
// seven_seg_scan_n
// Multiplexed common-anode seven-segment scanner for DIGITS digits.
// A load strobe captures value/dp_in into a shadow register; the shadow is
// copied into the display register only at frame boundaries so a frame never
// mixes old and new digits. Each digit slot starts with DEAD_CYCLES of all
// anodes off to suppress ghosting. Digits can be disabled, blinked and
// leading-zero blanked.
//
// Ports
//   clk        : system clock, rising edge
//   clr        : synchronous active-high reset
//   bus.load       : one-cycle strobe, captures value/dp_in into the shadow
//   bus.value      : packed hex nibbles, digit 0 rightmost
//   bus.dp_in      : decimal point per digit, 1 = lit
//   bus.digit_en   : per-digit enable (live)
//   bus.blank_lz   : leading-zero blanking enable (live)
//   bus.blink_mask : digits that blink (live)
//   bus.seg_n      : segments {g,f,e,d,c,b,a}, active-low, registered
//   bus.dp_n       : decimal point, active-low, registered
//   bus.an_n       : anodes, active-low, registered, at most one low
//   bus.frame_done : one-cycle pulse after each frame boundary
// ---------------------------------------------------------------------------
module seven_seg_scan_n #(
    parameter int DIGITS       = 4,
    parameter int SCAN_DIV     = 50000,
    parameter int DEAD_CYCLES  = 16,
    parameter int BLINK_FRAMES = 64
) (
    input  logic               clk,
    input  logic               clr,
    seven_seg_scan_n_if.slave  bus
);
    localparam int SLOT_W  = (SCAN_DIV > 1)     ? $clog2(SCAN_DIV)     : 1;
    localparam int IDX_W   = (DIGITS > 1)       ? $clog2(DIGITS)       : 1;
    localparam int BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [SLOT_W-1:0]  SLOT_LAST  = SLOT_W'(SCAN_DIV - 1);
    localparam logic [SLOT_W-1:0]  SLOT_DEAD  = SLOT_W'(DEAD_CYCLES);
    localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(DIGITS - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_FRAMES - 1);

    // Scan counters
    logic [SLOT_W-1:0]   slot_cnt_reg,  slot_cnt_next;
    logic [IDX_W-1:0]    dig_idx_reg,   dig_idx_next;
    logic [BLINK_W-1:0]  blink_cnt_reg, blink_cnt_next;
    logic                blink_ph_reg,  blink_ph_next;

    // Shadow (written by load) and display (copied at frame boundary)
    logic [4*DIGITS-1:0] shadow_value_reg, shadow_value_next;
    logic [DIGITS-1:0]   shadow_dp_reg,    shadow_dp_next;
    logic [4*DIGITS-1:0] disp_value_reg,   disp_value_next;
    logic [DIGITS-1:0]   disp_dp_reg,      disp_dp_next;

    // Registered pin drivers
    logic [6:0]          seg_n_reg,      seg_n_next;
    logic                dp_n_reg,       dp_n_next;
    logic [DIGITS-1:0]   an_n_reg,       an_n_next;
    logic                frame_done_reg, frame_done_next;

    logic                slot_wrap;
    logic                frame_end;
    logic                drive;
    logic [DIGITS-1:0]   nib_zero;
    logic [DIGITS-1:0]   visible;
    logic [3:0]          disp_nib [DIGITS];

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'b1000000;
            4'h1:    seg = 7'b1111001;
            4'h2:    seg = 7'b0100100;
            4'h3:    seg = 7'b0110000;
            4'h4:    seg = 7'b0011001;
            4'h5:    seg = 7'b0010010;
            4'h6:    seg = 7'b0000010;
            4'h7:    seg = 7'b1111000;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0010000;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b0000011;
            4'hC:    seg = 7'b1000110;
            4'hD:    seg = 7'b0100001;
            4'hE:    seg = 7'b0000110;
            default: seg = 7'b0001110;
        endcase
        return seg;
    endfunction

    // Per-digit visibility. A digit is leading-blanked when it and every
    // digit to its left hold zero; digit 0 always shows so "0" stays visible.
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
        assign disp_nib[gi] = disp_value_reg[4*gi +: 4];
        assign nib_zero[gi] = (disp_value_reg[4*gi +: 4] == 4'h0);
        if (gi == 0) begin : g_first
            assign visible[gi] = bus.digit_en[gi]
                               & ~(bus.blink_mask[gi] & blink_ph_reg);
        end else begin : g_rest
            assign visible[gi] = bus.digit_en[gi]
                               & ~(bus.blink_mask[gi] & blink_ph_reg)
                               & ~(bus.blank_lz & (&nib_zero[DIGITS-1:gi]));
        end
    end

    // Counter and register next-state
    always_comb begin
        slot_wrap = (slot_cnt_reg == SLOT_LAST);
        frame_end = slot_wrap && (dig_idx_reg == IDX_LAST);

        slot_cnt_next     = slot_wrap ? '0 : slot_cnt_reg + 1'b1;
        dig_idx_next      = dig_idx_reg;
        blink_cnt_next    = blink_cnt_reg;
        blink_ph_next     = blink_ph_reg;
        shadow_value_next = shadow_value_reg;
        shadow_dp_next    = shadow_dp_reg;
        disp_value_next   = disp_value_reg;
        disp_dp_next      = disp_dp_reg;

        if (slot_wrap) begin
            dig_idx_next = (dig_idx_reg == IDX_LAST) ? '0 : dig_idx_reg + 1'b1;
        end

        if (frame_end) begin
            // Pre-edge shadow: a load on this same edge waits a frame.
            disp_value_next = shadow_value_reg;
            disp_dp_next    = shadow_dp_reg;
            if (blink_cnt_reg == BLINK_LAST) begin
                blink_cnt_next = '0;
                blink_ph_next  = ~blink_ph_reg;
            end else begin
                blink_cnt_next = blink_cnt_reg + 1'b1;
            end
        end

        if (bus.load) begin
            shadow_value_next = bus.value;
            shadow_dp_next    = bus.dp_in;
        end
    end

    // Pin next-state, computed from the current (pre-edge) scan position
    always_comb begin
        drive           = (slot_cnt_reg >= SLOT_DEAD) && visible[dig_idx_reg];
        an_n_next       = '1;
        seg_n_next      = 7'h7F;
        dp_n_next       = 1'b1;
        frame_done_next = frame_end;
        if (drive) begin
            an_n_next[dig_idx_reg] = 1'b0;
            seg_n_next             = hex_to_seg(disp_nib[dig_idx_reg]);
            dp_n_next              = ~disp_dp_reg[dig_idx_reg];
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            slot_cnt_reg     <= '0;
            dig_idx_reg      <= '0;
            blink_cnt_reg    <= '0;
            blink_ph_reg     <= 1'b0;
            shadow_value_reg <= '0;
            shadow_dp_reg    <= '0;
            disp_value_reg   <= '0;
            disp_dp_reg      <= '0;
            seg_n_reg        <= 7'h7F;
            dp_n_reg         <= 1'b1;
            an_n_reg         <= '1;
            frame_done_reg   <= 1'b0;
        end else begin
            slot_cnt_reg     <= slot_cnt_next;
            dig_idx_reg      <= dig_idx_next;
            blink_cnt_reg    <= blink_cnt_next;
            blink_ph_reg     <= blink_ph_next;
            shadow_value_reg <= shadow_value_next;
            shadow_dp_reg    <= shadow_dp_next;
            disp_value_reg   <= disp_value_next;
            disp_dp_reg      <= disp_dp_next;
            seg_n_reg        <= seg_n_next;
            dp_n_reg         <= dp_n_next;
            an_n_reg         <= an_n_next;
            frame_done_reg   <= frame_done_next;
        end
    end

    assign bus.seg_n      = seg_n_reg;
    assign bus.dp_n       = dp_n_reg;
    assign bus.an_n       = an_n_reg;
    assign bus.frame_done = frame_done_reg;
endmodule

// File: doc/seven_seg_scan_n.md
# seven_seg_scan_n

Parametrised multiplexed seven-segment driver for the calculator front panel, the successor to the fixed 4-digit scanner. It drives DIGITS common-anode digits from a packed hex value. Its additions are:
- a load-strobed shadow register with tear-free frame-boundary update;
- anode dead time to suppress ghosting;
- per-digit enable, decimal point and blink;
- optional leading-zero blanking.

It sits between the calculator datapath/result register and the board's segment/anode pins.

## Interface
- DIGITS, 4: number of digits scanned, legal range 1..8.
- SCAN_DIV, 50000: clk cycles per digit slot. Must satisfy SCAN_DIV ≥ DEAD_CYCLES+2.
- DEAD_CYCLES, 16: cycles at the start of each slot during which all anodes are off.
- BLINK_FRAMES, 64: frames per blink half-period, ≥1.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- clr  in  1  reset, synchronous, active-high.
- load  in  1  one-cycle strobe; captures value and dp_in into the shadow register.
- value  in  4*DIGITS  packed hex nibbles; digit k = value[4k+3:4k], with digit 0 rightmost.
- dp_in  in  DIGITS  decimal point per digit, 1 = lit.
- digit_en  in  DIGITS  per-digit enable, 0 = digit always dark. Sampled live.
- blank_lz  in  1  leading-zero blanking enable. Sampled live.
- blink_mask  in  DIGITS  digits that blink. Sampled live.
- seg_n  out  7  segments {g,f,e,d,c,b,a}, active-low, registered.
- dp_n  out  1  decimal point, active-low, registered.
- an_n  out  DIGITS  anodes, active-low, registered; at most one bit low at any time.
- frame_done  out  1  one-cycle pulse at each frame boundary.

## Operation
- **slot_cnt**: counts 0..SCAN_DIV-1 and wraps to 0.
- **dig_idx**: increments when slot_cnt wraps; it wraps DIGITS-1 → 0.
- **Frame boundary**: the edge where slot_cnt = SCAN_DIV-1 and dig_idx = DIGITS-1. Frame length is DIGITS*SCAN_DIV cycles.
- **Shadow register** (value, dp_in): written on the edge where load = 1.
- **Display register**: copies the shadow on each frame boundary edge, using the pre-edge shadow contents.
  - A load on the boundary cycle therefore appears one frame later.
- **Blink phase**: a frame counter counts 0..BLINK_FRAMES-1; blink_ph toggles when it wraps.
- **Visibility**: digit k is visible iff all of the following hold:
  - digit_en[k] = 1;
  - not (blink_mask[k] and blink_ph = 1);
  - not leading-blanked.
- **Leading-blanked**: blank_lz = 1, k ≠ 0, and display nibbles k..DIGITS-1 are all zero. Digit 0 is never leading-blanked.
- **Next-state outputs**:
  - an_n: all ones except bit dig_idx = 0, when slot_cnt ≥ DEAD_CYCLES and digit dig_idx is visible.
  - seg_n: hex decode of nibble dig_idx when that anode is driven, else 7'h7F.
  - dp_n: ~dp[dig_idx] when that anode is driven, else 1.
- **Decode** (gfedcba, active-low):
  - 0 = 1000000
  - 1 = 1111001
  - 2 = 0100100
  - 3 = 0110000
  - 4 = 0011001
  - 5 = 0010010
  - 6 = 0000010
  - 7 = 1111000
  - 8 = 0000000
  - 9 = 0010000
  - A = 0001000
  - b = 0000011
  - C = 1000110
  - d = 0100001
  - E = 0000110
  - F = 0001110

## Timing
- **Reset values** (while clr = 1 and on the edge it is sampled): slot_cnt = 0, dig_idx = 0, frame counter = 0, blink_ph = 0, shadow = 0, display = 0, seg_n = 7'h7F, dp_n = 1, an_n = all ones, frame_done = 0.
- **clr priority**: clr overrides load and all counting. Reset mid-frame discards the frame and the shadow contents.
- **Output latency**: outputs lag the counters by one cycle.
  - After clr deasserts at edge 0, an_n[0] first goes low at edge DEAD_CYCLES+1.
  - an_n[0] stays low for SCAN_DIV-DEAD_CYCLES cycles.
- **frame_done**: high for exactly the cycle after each frame boundary edge. The period is DIGITS*SCAN_DIV cycles.
- **Load timing**: shadow updates 1 cycle after load. The display shows the new value from the first slot of the following frame; no partial frame mixes old and new digits.
- **Live-sampled inputs** (digit_en, blink_mask, blank_lz): take effect on the next output register edge.
- **Dead time**: during it, all anodes are off and seg_n = 7'h7F.
- **DIGITS = 1**: dig_idx stays 0, and every slot is a frame boundary.

## Test plan
Parameters: DIGITS=4, SCAN_DIV=8, DEAD_CYCLES=2, BLINK_FRAMES=2.
1. **Reset**: hold clr 3 cycles, then release → seg_n = 7F, an_n = F, dp_n = 1, frame_done = 0 throughout reset; an_n = 1110 first at cycle 3 after release; frame_done every 32 cycles.
2. **Basic scan**: load 16'h12AF with all enables on → from the next frame:
   - digit0: an_n = 1110, seg_n = 0001110;
   - digit1: an_n = 1101, seg_n = 0001000;
   - digit2: seg_n = 0100100;
   - digit3: an_n = 0111, seg_n = 1111001.
   - Each digit is lit 6 of 8 cycles.
3. **Leading-zero blanking**: blank_lz = 1 with value 16'h0050 → an_n[3] and an_n[2] never low; digit1 shows 0010010, digit0 shows 1000000. With value 0 → only digit0 lit (1000000).
4. **Tear-free load**: load 16'h1111 mid-frame, then 16'h2222 on the boundary cycle → remainder of the current frame shows the old value; next frame shows 1111 on all digits; the frame after shows 2222.
5. **Blink, enable, decimal point**: blink_mask = 0001 → digit0 lit 2 frames, dark 2 frames, repeating. digit_en = 1011 → an_n[2] never low. dp_in = 0100 → dp_n low only in digit2 slots.
6. **Mid-frame reset**: pulse clr during the digit2 slot → next cycle all outputs at reset values; the display register is zero, so the next frame shows 0 on every enabled digit.
